// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared single-port memory.
// Grants one requester at a time, drives the registered memory strobes and returns a one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1,
    parameter int FIXED_PRIO    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] ACC_LOAD = 3'(ACCESS_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rr_q, rr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;

    logic              pref;
    logic              win;
    logic              win_we;

    // rr_q names the port preferred on a tie; a lone request always wins.
    always_comb begin
        pref   = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        win    = (req0 && req1) ? pref : req1;
        win_we = win ? we1 : we0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rr_d     = rr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rd_en_d  = rd_en_q;
        wr_en_d  = wr_en_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    cnt_d   = ACC_LOAD;
                    sel_d   = win;
                    we_d    = win_we;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    rr_d    = ~win;
                    rd_en_d = ~win_we;
                    wr_en_d = win_we;
                    oe_d    = win_we;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q <= 3'd1) begin
                    // Last strobe cycle: read data is captured on the same edge that raises ack.
                    state_d = RESP;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    oe_d    = 1'b0;
                    if (sel_q) begin
                        ack1_d = 1'b1;
                        if (!we_q) rdata1_d = mem_rdata;
                    end else begin
                        ack0_d = 1'b1;
                        if (!we_q) rdata0_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rr_q     <= rr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wdata_oe = oe_q;
    assign busy         = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and access sequencer for the shared single-port memory (5-bit address, 8-bit bidirectional data bus, read_en/write_en strobes). Port 0 is the CPU fetch/execute side; port 1 is the loader/debug side. The block grants one requester at a time, drives the memory strobes, address and write data, captures read data, and returns a one-cycle acknowledge. It sits between the CPU core, the loader and the memory instance; top level joins mem_wdata/mem_wdata_oe/mem_rdata onto the tristate data bus.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 8, memory data width
ACCESS_CYCLES, 1, cycles each strobe is held (1..7)
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req0  in  1  port 0 request, held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_read_en  out  1  memory read strobe
mem_write_en  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  data driven onto bus
mem_wdata_oe  out  1  bus drive enable; high only during write access
mem_rdata  in  DATA_W  data bus as seen by arbiter
busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; rr pointer = port 0 preferred; rdata0/rdata1 = 0.
- All outputs registered; no combinational path from req*/addr* to mem_*.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: at a rising edge with any req high, select winner, latch its we/addr/wdata into internal regs, enter ACCESS. No req: stay.
- Selection: single req wins. Both high: FIXED_PRIO=1 -> port 0. FIXED_PRIO=0 -> port not served last; after reset port 0.
- ACCESS: held exactly ACCESS_CYCLES cycles (down-counter). mem_addr = latched address throughout. Write: mem_write_en=1, mem_wdata_oe=1, mem_wdata = latched data. Read: mem_read_en=1, oe=0. Read data sampled from mem_rdata at the edge ending the last ACCESS cycle.
- RESP: one cycle. Strobes and oe 0; mem_addr holds value. Winner's ack = 1 for this cycle only. For a read, winner's rdata updates at RESP entry and holds until that port's next read completes. Writes leave rdata unchanged. Other port's ack/rdata untouched.
- Latency: req sampled at edge E -> strobes high for cycles E+1..E+ACCESS_CYCLES -> ack in cycle E+ACCESS_CYCLES+1. Next grant is sampled at the edge leaving RESP's following IDLE cycle, giving one idle bus cycle (turnaround, no write/read overlap). Throughput: one access per ACCESS_CYCLES+2 cycles.
- req held high after ack: treated as a new request (requester must drop req in the ack cycle to avoid a repeat).
- req dropped or addr/wdata changed mid-transaction: ignored. Latched values are used and ack is still pulsed.
- mem_read_en and mem_write_en are never both high. oe is never high while read_en is high.
- Reset mid-ACCESS: strobes/oe drop asynchronously, transaction abandoned, no ack, memory content at that address undefined for an interrupted write.
- rr pointer updates only on a grant; unchanged while idle.

Test Plan:
- Port 0 writes 0x35 to 0x15, 0xC1 to 0x17, 0xFF to 0x19, 0xB4 to 0x13 (ACCESS_CYCLES=1). Each: mem_write_en is high exactly 1 cycle with the correct addr/data, oe is high the same cycle, and ack0 pulses 2 cycles after req is sampled. Port 0 then reads 0x17: rdata0=0xC1 with ack0, and mem_read_en is high 1 cycle.
- Port 1 overwrites 0x17 with 0xA5, then port 0 reads 0x15 and 0x17. Expect rdata0=0x35, then 0xA5; ack1 pulses once; ack0 never pulses during port 1's transaction.
- req0 and req1 raised in the same cycle, held through 4 transactions (round-robin). Grant order is 0,1,0,1, with exactly one idle cycle between RESP and the next strobe. With FIXED_PRIO=1, grant order is 0,0,0,0 and port 1 is starved.
- ACCESS_CYCLES=3, read of 0x19. Strobe is high 3 consecutive cycles; mem_rdata changed before the final edge is captured (0xFF); ack in cycle 4 after the grant.
- req0 write with addr0 changed mid-ACCESS and req0 dropped. mem_addr stays at the latched value and ack0 still pulses once. Separately, rst asserted in the middle of an ACCESS cycle: mem_write_en/oe fall before the next edge, no ack, busy=0, and the next request is served normally.
